// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// coin denominations and the default currency width.
package change_pkg;

  localparam int DEF_CURRENCY_WIDTH = 7;

  localparam int COIN_20 = 20;
  localparam int COIN_10 = 10;
  localparam int COIN_5  = 5;
  localparam int COIN_1  = 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    VEND,
    CHANGE,
    DONE
  } state_e;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: returns the largest denomination that fits in the credit,
// or zero when there is no credit left.
module coin_select
  import change_pkg::*;
#(
  parameter int W = DEF_CURRENCY_WIDTH
) (
  input  logic [W-1:0] credit,
  output logic [W-1:0] coin
);

  always_comb begin
    coin = '0;
    if (credit >= W'(COIN_20))      coin = W'(COIN_20);
    else if (credit >= W'(COIN_10)) coin = W'(COIN_10);
    else if (credit >= W'(COIN_5))  coin = W'(COIN_5);
    else if (credit >= W'(COIN_1))  coin = W'(COIN_1);
  end

endmodule

// File: rtl/change_dispense.sv
// Purchase/refund sequencer: checks credit against price, vends, pays change
// one coin per handshake, then pulses currency_clear to zero the accumulator.
module change_dispense
  import change_pkg::*;
#(
  parameter int CURRENCY_WIDTH = DEF_CURRENCY_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CURRENCY_WIDTH-1:0] total_currency,
  input  logic                      currency_avail,
  input  logic [CURRENCY_WIDTH-1:0] product_price,
  input  logic                      purchase_req,
  input  logic                      cancel_req,
  output logic                      product_valid,
  input  logic                      product_ready,
  output logic                      coin_valid,
  output logic [CURRENCY_WIDTH-1:0] coin_value,
  input  logic                      coin_ready,
  output logic                      currency_clear,
  output logic                      err_insufficient,
  output logic                      busy
);

  state_e                    state_q, state_d;
  logic [CURRENCY_WIDTH-1:0] credit_q, credit_d;
  logic [CURRENCY_WIDTH-1:0] price_q, price_d;
  logic                      err_q, err_d;
  logic [CURRENCY_WIDTH-1:0] coin_sel;
  logic [CURRENCY_WIDTH-1:0] credit_left;

  coin_select #(.W(CURRENCY_WIDTH)) u_coin_select (
    .credit (credit_q),
    .coin   (coin_sel)
  );

  assign credit_left = credit_q - coin_sel;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (purchase_req) begin
          if (currency_avail) begin
            credit_d = total_currency;
            price_d  = product_price;
            state_d  = CHECK;
          end else begin
            err_d = 1'b1;
          end
        end else if (cancel_req && currency_avail) begin
          credit_d = total_currency;
          state_d  = CHANGE;
        end
      end
      CHECK: begin
        if (credit_q >= price_q) begin
          credit_d = credit_q - price_q;
          state_d  = VEND;
        end else begin
          // Refused purchase leaves the credit in the accumulator: no clear.
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      VEND: begin
        if (product_ready) state_d = (credit_q != '0) ? CHANGE : DONE;
      end
      CHANGE: begin
        if (coin_ready) begin
          credit_d = credit_left;
          if (credit_left == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode registered state only, so ready never feeds valid/value.
  assign product_valid    = (state_q == VEND);
  assign coin_valid       = (state_q == CHANGE);
  assign coin_value       = coin_valid ? coin_sel : '0;
  assign currency_clear   = (state_q == DONE);
  assign busy             = (state_q != IDLE);
  assign err_insufficient = err_q;

endmodule

// File: tb/tb_change_dispense.sv
// Randomized and directed bench for change_dispense against a transaction-level
// model (greedy change computed arithmetically per request).
module tb_change_dispense;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] total_currency = '0;
  logic         currency_avail = 1'b0;
  logic [W-1:0] product_price = '0;
  logic         purchase_req = 1'b0;
  logic         cancel_req = 1'b0;
  logic         product_valid;
  logic         product_ready = 1'b1;
  logic         coin_valid;
  logic [W-1:0] coin_value;
  logic         coin_ready = 1'b1;
  logic         currency_clear;
  logic         err_insufficient;
  logic         busy;

  change_dispense #(.CURRENCY_WIDTH(W)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .total_currency   (total_currency),
    .currency_avail   (currency_avail),
    .product_price    (product_price),
    .purchase_req     (purchase_req),
    .cancel_req       (cancel_req),
    .product_valid    (product_valid),
    .product_ready    (product_ready),
    .coin_valid       (coin_valid),
    .coin_value       (coin_value),
    .coin_ready       (coin_ready),
    .currency_clear   (currency_clear),
    .err_insufficient (err_insufficient),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor state
  int cyc = 0;
  int n_vend, n_clear, n_err;
  int coins[$];
  int first_pv, first_cv, err_cyc, clear_cyc, last_hs;
  int mode = 0;  // 0: readies high, 1: random readies, 2: stall second coin 3 cycles
  int hold_cnt;
  logic prev_cv = 1'b0, prev_cr = 1'b0, prev_pv = 1'b0, prev_pr = 1'b0;
  logic [W-1:0] prev_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clr_mon();
    n_vend = 0; n_clear = 0; n_err = 0;
    coins.delete();
    first_pv = -1; first_cv = -1; err_cyc = -1; clear_cyc = -1; last_hs = -1;
    hold_cnt = 0;
  endtask

  // Ready driver then monitor, both on the falling edge so the sampled
  // valid/ready pair is exactly what the next rising edge will see.
  initial begin
    clr_mon();
    forever begin
      @(negedge clk);
      case (mode)
        1: begin
          product_ready = 1'($urandom_range(0, 1));
          coin_ready    = 1'($urandom_range(0, 1));
        end
        2: begin
          product_ready = 1'b1;
          if (coins.size() == 1 && hold_cnt < 3 && coin_valid) begin
            coin_ready = 1'b0;
            hold_cnt++;
          end else begin
            coin_ready = 1'b1;
          end
        end
        default: begin
          product_ready = 1'b1;
          coin_ready    = 1'b1;
        end
      endcase
      if (!rstn) begin
        prev_cv = 1'b0;
        prev_pv = 1'b0;
      end else begin
        if (prev_cv && !prev_cr) begin
          chk("coin_hold_valid", int'(coin_valid), 1);
          chk("coin_hold_value", int'(coin_value), int'(prev_val));
        end
        if (prev_pv && !prev_pr) chk("vend_hold", int'(product_valid), 1);
        if (product_valid && first_pv < 0) first_pv = cyc;
        if (coin_valid && first_cv < 0) first_cv = cyc;
        if (product_valid && product_ready) begin n_vend++; last_hs = cyc; end
        if (coin_valid && coin_ready) begin coins.push_back(int'(coin_value)); last_hs = cyc; end
        if (currency_clear) begin n_clear++; clear_cyc = cyc; end
        if (err_insufficient) begin n_err++; err_cyc = cyc; end
        prev_cv = coin_valid; prev_cr = coin_ready;
        prev_pv = product_valid; prev_pr = product_ready;
        prev_val = coin_value;
      end
    end
  end

  task automatic run_txn(input bit p, input bit c, input int total, input bit avail,
                         input int price, input string tag);
    int exp_err, exp_err_lat, exp_vend, exp_clear, ch, t0;
    int exp_coins[$];
    bit done;
    // reference: what one request should produce
    exp_err = 0; exp_err_lat = 0; exp_vend = 0; ch = 0;
    if (p) begin
      if (!avail) begin exp_err = 1; exp_err_lat = 1; end
      else if (total < price) begin exp_err = 1; exp_err_lat = 2; end
      else begin exp_vend = 1; ch = total - price; end
    end else if (c && avail) begin
      ch = total;
    end
    exp_clear = (exp_vend == 1 || (!p && c && avail)) ? 1 : 0;
    while (ch > 0) begin
      if (ch >= 20) begin exp_coins.push_back(20); ch -= 20; end
      else if (ch >= 10) begin exp_coins.push_back(10); ch -= 10; end
      else if (ch >= 5) begin exp_coins.push_back(5); ch -= 5; end
      else begin exp_coins.push_back(1); ch -= 1; end
    end

    @(posedge clk); #1;
    clr_mon();
    @(negedge clk);
    total_currency = W'(total); currency_avail = avail; product_price = W'(price);
    purchase_req = p; cancel_req = c;
    t0 = cyc;
    @(negedge clk);
    purchase_req = 1'b0; cancel_req = 1'b0;
    // inputs after the accepting edge must not matter
    total_currency = W'($urandom); product_price = W'($urandom);
    currency_avail = 1'($urandom_range(0, 1));
    done = 1'b0;
    for (int k = 2; k < 400; k++) begin
      @(negedge clk);
      purchase_req = 1'b0; cancel_req = 1'b0;
      if (k >= 3 && !busy) begin done = 1'b1; break; end
      if (k == 3) begin
        purchase_req = 1'($urandom_range(0, 1));
        cancel_req   = 1'($urandom_range(0, 1));
      end
    end
    currency_avail = 1'b0;
    if (!done) chk({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk);

    chk({tag, "_vend"}, n_vend, exp_vend);
    chk({tag, "_ncoin"}, coins.size(), exp_coins.size());
    foreach (exp_coins[i])
      if (i < coins.size()) chk($sformatf("%s_coin%0d", tag, i), coins[i], exp_coins[i]);
    chk({tag, "_clear"}, n_clear, exp_clear);
    chk({tag, "_err"}, n_err, exp_err);
    if (exp_err == 1) chk({tag, "_err_lat"}, err_cyc - t0, exp_err_lat);
    if (exp_vend == 1) chk({tag, "_pv_lat"}, first_pv - t0, 2);
    if (!p && c && avail) chk({tag, "_cv_lat"}, first_cv - t0, 1);
    if (exp_clear == 1) chk({tag, "_clear_lat"}, clear_cyc - last_hs, 1);
    if (mode == 0 && exp_coins.size() > 0)
      chk({tag, "_b2b"}, last_hs - first_cv, exp_coins.size() - 1);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int tot, pr, kind;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pv", int'(product_valid), 0);
    chk("rst_cv", int'(coin_valid), 0);
    chk("rst_coinval", int'(coin_value), 0);
    chk("rst_clear", int'(currency_clear), 0);
    chk("rst_err", int'(err_insufficient), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    mode = 0; run_txn(1, 0, 35, 1, 15, "p35_15");
    mode = 2; run_txn(1, 0, 38, 1, 15, "p38_15_stall");
    mode = 0; run_txn(1, 0, 38, 1, 15, "p38_15");
    run_txn(1, 0, 10, 1, 15, "p10_15");
    run_txn(0, 1, 27, 1, 0, "c27");
    run_txn(1, 1, 27, 1, 7, "pc27_7");
    run_txn(1, 0, 15, 1, 15, "p15_15");
    run_txn(1, 0, 0, 0, 15, "p0");
    run_txn(0, 1, 0, 0, 0, "c0");
    run_txn(1, 0, 127, 1, 0, "p127_0");

    // reset in the middle of paying change
    @(posedge clk); #1; clr_mon();
    @(negedge clk);
    total_currency = 7'd38; currency_avail = 1'b1; product_price = 7'd0; purchase_req = 1'b1;
    @(negedge clk);
    purchase_req = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (coins.size() == 1) begin ok = 1'b1; break; end
    end
    chk("rstmid_first_coin", int'(ok), 1);
    @(posedge clk); #2;
    chk("rstmid_in_change", int'(coin_valid), 1);
    rstn = 1'b0; #1;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_cv", int'(coin_valid), 0);
    chk("rstmid_coinval", int'(coin_value), 0);
    chk("rstmid_pv", int'(product_valid), 0);
    chk("rstmid_clear", int'(currency_clear), 0);
    chk("rstmid_err", int'(err_insufficient), 0);
    currency_avail = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_no_clear", n_clear, 0);
    run_txn(0, 1, 5, 1, 0, "post_rst_c5");

    for (int i = 0; i < 40; i++) begin
      mode = (i % 3 == 0) ? 0 : 1;
      tot  = $urandom_range(0, 127);
      kind = $urandom_range(0, 3);
      pr   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, tot);
      run_txn(kind != 1, kind == 1 || kind == 2, tot, tot != 0, pr, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/change_dispense.md
Name: change_dispense

Overview:
- Money-out counterpart of the currency accumulator. It takes the accumulated credit on a purchase or cancel request, checks it against the product price, and issues a product-vend handshake.
- It then pays out the remaining credit as change, one coin per ready/valid handshake, using greedy denominations 20/10/5/1.
- It pulses currency_clear so the accumulator zeroes its total. It sits between the accumulator, the product actuator and the coin hopper.

Parameters:
- CURRENCY_WIDTH, 7, width of all currency/price/coin values (max credit 127).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- total_currency  in  CURRENCY_WIDTH  credit from the accumulator.
- currency_avail  in  1  credit is non-zero and valid.
- product_price  in  CURRENCY_WIDTH  price of the selected product.
- purchase_req  in  1  single-cycle purchase request.
- cancel_req  in  1  single-cycle refund request.
- product_valid  out  1  vend command, held until accepted.
- product_ready  in  1  actuator accepts the vend.
- coin_valid  out  1  change coin offered to the hopper.
- coin_value  out  CURRENCY_WIDTH  denomination of the offered coin.
- coin_ready  in  1  hopper accepts the coin.
- currency_clear  out  1  one-cycle pulse that clears the accumulator.
- err_insufficient  out  1  one-cycle pulse when a purchase is refused.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock domain. rstn is asynchronous and active-low. Reset forces state IDLE and zeroes credit_r, price_r and every output.
- Reset mid-operation: a coin or vend handshake in progress is abandoned. No currency_clear is issued.
- IDLE:
  - purchase_req=1 and currency_avail=1: latch total_currency into credit_r and product_price into price_r, go to CHECK.
  - purchase_req=1 and currency_avail=0: pulse err_insufficient the next cycle, stay in IDLE.
  - cancel_req=1 and currency_avail=1: latch credit_r, go straight to CHANGE (refund, no vend).
  - purchase_req and cancel_req together: purchase wins and cancel is ignored.
  - cancel_req with currency_avail=0: ignored.
- CHECK (exactly 1 cycle):
  - credit_r >= price_r: credit_r <= credit_r - price_r, go to VEND.
  - Otherwise: pulse err_insufficient, go to IDLE, no clear (the credit stays in the accumulator).
  - Comparison and subtraction are unsigned at CURRENCY_WIDTH. Underflow cannot occur.
- VEND:
  - product_valid=1 from the first VEND cycle, held until the product_valid & product_ready cycle.
  - After the handshake: go to CHANGE if credit_r != 0, else DONE.
  - price_r = 0 is legal and vends with the full credit returned as change.
- CHANGE:
  - coin_valid=1 with coin_value = largest of {20,10,5,1} <= credit_r.
  - coin_value stays stable while coin_valid=1 and coin_ready=0. There is no combinational path from coin_ready to coin_valid or coin_value.
  - On a coin_valid & coin_ready cycle: credit_r <= credit_r - coin_value. If the result is 0, go to DONE (coin_valid low next cycle). Otherwise the next coin is offered the following cycle, giving at most one coin per cycle back to back.
- DONE: currency_clear=1 for exactly one cycle, then IDLE.
- purchase_req and cancel_req are ignored while busy=1.
- Inputs total_currency and product_price are sampled only on the accepting IDLE edge. Later changes have no effect on the transaction.
- Latency:
  - Purchase accept to product_valid: 2 cycles (IDLE→CHECK→VEND).
  - Cancel accept to coin_valid: 1 cycle.

Decomposition:
- Package change_pkg:
  - state enum {IDLE, CHECK, VEND, CHANGE, DONE}.
  - denomination constants COIN_20, COIN_10, COIN_5, COIN_1.
  - CURRENCY_WIDTH default.
- Sub-module coin_select: combinational greedy picker, credit in → coin_value out. The top-level FSM instantiates it once.

Test Plan:
- total=35, price=15, purchase_req, ready lines tied high → product_valid one handshake, then a single coin 20, then currency_clear one cycle, busy low.
- total=38, price=15 → coins 20,1,1,1 in order, back to back with coin_ready=1. Hold coin_ready=0 for 3 cycles on the second coin → coin_value stays 1 and coin_valid stays high; total coin count 4.
- total=10, price=15 → err_insufficient pulse after CHECK, no product_valid, no coin, no currency_clear.
- total=27, cancel_req → coins 20,5,1,1, no product_valid, then currency_clear. Repeat with purchase_req and cancel_req together (price=7) → vend path taken, coins 20 only.
- total=15, price=15 → product handshake then DONE directly, zero coins, currency_clear one cycle after the handshake. Also total=0 (currency_avail=0) with purchase_req → err_insufficient only.
- total=38, price=0, drop rstn mid-CHANGE after the first coin → all outputs 0 asynchronously, state IDLE, no clear. A new cancel with total=5 then yields a single coin 5.
